// File: rtl/char_motion_ctrl.sv
// Per-player character controller: keyboard make/break events -> held-key set,
// frame-tick driven walk/jump/attack/hurt/death. Optional macro: DOUBLE_JUMP_EN.
module char_motion_ctrl #(
    parameter int         X_W        = 10,
    parameter int         SCR_W      = 640,
    parameter int         SPR_W      = 32,
    parameter int         X_INIT     = 100,
    parameter int         GROUND_Y   = 400,
    parameter int         STEP       = 2,
    parameter int         JUMP_V     = 12,
    parameter int         GRAV       = 1,
    parameter int         TICK_DIV   = 833333,
    parameter int         ATK_TICKS  = 12,
    parameter int         HURT_TICKS = 20,
    parameter int         HP_MAX     = 100,
    parameter logic [9:0] KEY_L      = 10'h06B,
    parameter logic [9:0] KEY_R      = 10'h074,
    parameter logic [9:0] KEY_J      = 10'h075,
    parameter logic [9:0] KEY_A      = 10'h029
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_key_valid,
    input  logic [9:0]     i_keycode,
    input  logic           i_key_break,
    input  logic           i_hit,
    input  logic [7:0]     i_hit_dmg,
    output logic [X_W-1:0] o_x,
    output logic [X_W-1:0] o_y,
    output logic [2:0]     o_state,
    output logic           o_facing,
    output logic [4:0]     o_gesture,
    output logic [7:0]     o_hp,
    output logic           o_tick
);

    localparam int CW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int XS    = X_W + 1;
    localparam int YS    = X_W + 2;
    localparam int X_MAX = SCR_W - SPR_W;

    localparam logic signed [7:0] VY_JUMP = 8'(-JUMP_V);
    localparam logic signed [7:0] VY_MAX  = 8'sd127;
    localparam logic signed [7:0] VY_MIN  = -8'sd127;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WALK   = 3'd1,
        ST_JUMP   = 3'd2,
        ST_ATTACK = 3'd3,
        ST_HURT   = 3'd4,
        ST_DEAD   = 3'd5
    } state_t;

    logic [CW-1:0]     cnt_q;
    logic              held_l_q;
    logic              held_r_q;
    logic              held_j_q;
    logic              held_a_q;
    state_t            state_q;
    logic [X_W-1:0]    x_q;
    logic [X_W-1:0]    y_q;
    logic signed [7:0] vy_q;
    logic              facing_q;
    logic [7:0]        timer_q;
    logic [7:0]        hp_q;
    logic [1:0]        frame_q;
    logic [2:0]        fdiv_q;
`ifdef DOUBLE_JUMP_EN
    logic              dj_arm_q;
    logic              j_prev_q;
`endif

    logic               tick;
    logic               move_l;
    logic               move_r;
    logic signed [XS-1:0] x_ext;
    logic signed [XS-1:0] x_sum;
    logic [X_W-1:0]     x_d;
    logic signed [YS-1:0] y_sum;
    logic [X_W-1:0]     y_d;
    logic               landed;
    logic signed [9:0]  vy_sum;
    logic signed [7:0]  vy_grav;
    logic [7:0]         hp_after;
    logic               hit_ok;

    // Frame tick divider; motion only advances on the wrap cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else if (cnt_q == CW'(TICK_DIV - 1)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick = (cnt_q == CW'(TICK_DIV - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            held_l_q <= 1'b0;
            held_r_q <= 1'b0;
            held_j_q <= 1'b0;
            held_a_q <= 1'b0;
        end else if (i_key_valid) begin
            if (i_keycode == KEY_L) held_l_q <= ~i_key_break;
            if (i_keycode == KEY_R) held_r_q <= ~i_key_break;
            if (i_keycode == KEY_J) held_j_q <= ~i_key_break;
            if (i_keycode == KEY_A) held_a_q <= ~i_key_break;
        end
    end

    // Opposing direction keys cancel each other.
    assign move_l = held_l_q & ~held_r_q;
    assign move_r = held_r_q & ~held_l_q;

    always_comb begin
        x_ext = $signed({1'b0, x_q});
        x_sum = x_ext;
        if (move_r) begin
            x_sum = x_ext + XS'(STEP);
        end else if (move_l) begin
            x_sum = x_ext - XS'(STEP);
        end
        if (x_sum < 0) begin
            x_d = '0;
        end else if (x_sum > XS'(X_MAX)) begin
            x_d = X_W'(X_MAX);
        end else begin
            x_d = x_sum[X_W-1:0];
        end
    end

    always_comb begin
        y_sum  = $signed({2'b00, y_q}) + YS'(vy_q);
        landed = 1'b0;
        if (y_sum >= YS'(GROUND_Y)) begin
            landed = 1'b1;
            y_d    = X_W'(GROUND_Y);
        end else if (y_sum < 0) begin
            y_d = '0;
        end else begin
            y_d = y_sum[X_W-1:0];
        end
    end

    always_comb begin
        vy_sum = 10'(vy_q) + 10'(GRAV);
        if (vy_sum > 10'(VY_MAX)) begin
            vy_grav = VY_MAX;
        end else if (vy_sum < 10'(VY_MIN)) begin
            vy_grav = VY_MIN;
        end else begin
            vy_grav = vy_sum[7:0];
        end
    end

    assign hp_after = (hp_q > i_hit_dmg) ? (hp_q - i_hit_dmg) : 8'd0;
    assign hit_ok   = i_hit && (state_q != ST_HURT) && (state_q != ST_DEAD);

    // Character FSM. A hit in the same cycle as a tick replaces the tick's update.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            x_q      <= X_W'(X_INIT);
            y_q      <= X_W'(GROUND_Y);
            vy_q     <= '0;
            facing_q <= 1'b0;
            timer_q  <= '0;
            hp_q     <= 8'(HP_MAX);
            frame_q  <= '0;
            fdiv_q   <= '0;
`ifdef DOUBLE_JUMP_EN
            dj_arm_q <= 1'b0;
            j_prev_q <= 1'b0;
`endif
        end else if (hit_ok) begin
            hp_q    <= hp_after;
            frame_q <= '0;
            fdiv_q  <= '0;
            if (hp_after == 8'd0) begin
                state_q <= ST_DEAD;
            end else begin
                state_q <= ST_HURT;
                timer_q <= 8'(HURT_TICKS);
                vy_q    <= '0;
                y_q     <= X_W'(GROUND_Y);
            end
        end else if (tick) begin
            frame_q <= '0;
            fdiv_q  <= '0;
`ifdef DOUBLE_JUMP_EN
            j_prev_q <= held_j_q;
`endif
            case (state_q)
                ST_IDLE, ST_WALK: begin
                    if (held_a_q) begin
                        state_q <= ST_ATTACK;
                        timer_q <= 8'(ATK_TICKS);
                    end else if (held_j_q) begin
                        state_q <= ST_JUMP;
                        vy_q    <= VY_JUMP;
`ifdef DOUBLE_JUMP_EN
                        dj_arm_q <= 1'b1;
`endif
                    end else if (move_l || move_r) begin
                        state_q  <= ST_WALK;
                        x_q      <= x_d;
                        facing_q <= move_l;
                        // Walk cycle frame advances every 8 ticks spent walking.
                        if (state_q == ST_WALK) begin
                            fdiv_q  <= fdiv_q + 3'd1;
                            frame_q <= (&fdiv_q) ? frame_q + 2'd1 : frame_q;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_JUMP: begin
                    x_q <= x_d;
                    if (move_l || move_r) facing_q <= move_l;
                    if (landed) begin
                        y_q     <= X_W'(GROUND_Y);
                        vy_q    <= '0;
                        state_q <= ST_IDLE;
`ifdef DOUBLE_JUMP_EN
                        dj_arm_q <= 1'b1;
`endif
                    end else begin
                        y_q  <= y_d;
                        vy_q <= vy_grav;
`ifdef DOUBLE_JUMP_EN
                        if (dj_arm_q && held_j_q && !j_prev_q) begin
                            vy_q     <= VY_JUMP;
                            dj_arm_q <= 1'b0;
                        end
`endif
                    end
                end
                ST_ATTACK, ST_HURT: begin
                    if (timer_q <= 8'd1) begin
                        timer_q <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        timer_q <= timer_q - 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_x       = x_q;
    assign o_y       = y_q;
    assign o_state   = state_q;
    assign o_facing  = facing_q;
    assign o_gesture = {state_q, frame_q};
    assign o_hp      = hp_q;
    assign o_tick    = tick;

endmodule

// File: tb/tb_char_motion_ctrl.sv
// Directed bench for char_motion_ctrl with a 4-clock frame tick; the double-jump
// scenario is exercised only when DOUBLE_JUMP_EN is defined.
module tb_char_motion_ctrl;
  localparam logic [9:0] K_L = 10'h06B;
  localparam logic [9:0] K_R = 10'h074;
  localparam logic [9:0] K_J = 10'h075;
  localparam logic [9:0] K_A = 10'h029;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [9:0] keycode = '0;
  logic       key_break = 1'b0;
  logic       hit = 1'b0;
  logic [7:0] hit_dmg = '0;
  logic [9:0] o_x;
  logic [9:0] o_y;
  logic [2:0] o_state;
  logic       o_facing;
  logic [4:0] o_gesture;
  logic [7:0] o_hp;
  logic       o_tick;

  int checks = 0;
  int errors = 0;

  char_motion_ctrl #(.TICK_DIV(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_key_valid(key_valid), .i_keycode(keycode),
    .i_key_break(key_break), .i_hit(hit), .i_hit_dmg(hit_dmg),
    .o_x(o_x), .o_y(o_y), .o_state(o_state), .o_facing(o_facing),
    .o_gesture(o_gesture), .o_hp(o_hp), .o_tick(o_tick)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic send_key(input logic [9:0] code, input logic brk);
    @(negedge clk);
    key_valid = 1'b1; keycode = code; key_break = brk;
    @(posedge clk); #1;
    key_valid = 1'b0; key_break = 1'b0;
  endtask

  task automatic send_hit(input logic [7:0] dmg);
    @(negedge clk);
    hit = 1'b1; hit_dmg = dmg;
    @(posedge clk); #1;
    hit = 1'b0;
  endtask

  task automatic wait_tick();
    int n = 0;
    @(negedge clk);
    while (!o_tick && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (!o_tick) begin
      checks++; errors++;
      $display("FAIL tick_timeout: no o_tick within 16 cycles, got %0b required 1", o_tick);
    end
    @(posedge clk); #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) wait_tick();
  endtask

  task automatic test_reset(input string tag);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (o_x !== 10'd100) begin errors++; $display("FAIL %s_x: got %0d required 100", tag, o_x); end
    checks++; if (o_y !== 10'd400) begin errors++; $display("FAIL %s_y: got %0d required 400", tag, o_y); end
    checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL %s_state: got %0d required 0", tag, o_state); end
    checks++; if (o_facing !== 1'b0) begin errors++; $display("FAIL %s_facing: got %0b required 0", tag, o_facing); end
    checks++; if (o_gesture !== 5'd0) begin errors++; $display("FAIL %s_gesture: got %0d required 0", tag, o_gesture); end
    checks++; if (o_hp !== 8'd100) begin errors++; $display("FAIL %s_hp: got %0d required 100", tag, o_hp); end
    checks++; if (o_tick !== 1'b0) begin errors++; $display("FAIL %s_tick: got %0b required 0", tag, o_tick); end
    rst_n = 1'b1;
  endtask

  task automatic test_walk();
    send_key(10'h01C, 1'b0);
    wait_tick();
    checks++; if (o_state !== 3'd0 || o_x !== 10'd100) begin errors++; $display("FAIL unmapped_key: got state %0d x %0d required 0/100", o_state, o_x); end
    send_key(10'h01C, 1'b1);
    send_key(K_R, 1'b0);
    ticks(10);
    checks++; if (o_state !== 3'd1) begin errors++; $display("FAIL walk_state: got %0d required 1", o_state); end
    checks++; if (o_x !== 10'd120) begin errors++; $display("FAIL walk_x: got %0d required 120", o_x); end
    checks++; if (o_facing !== 1'b0) begin errors++; $display("FAIL walk_facing: got %0b required 0", o_facing); end
    checks++; if (o_gesture[4:2] !== 3'd1) begin errors++; $display("FAIL walk_gesture: got %0d required state bits 1", o_gesture[4:2]); end
    send_key(K_R, 1'b1);
    wait_tick();
    checks++; if (o_state !== 3'd0 || o_x !== 10'd120) begin errors++; $display("FAIL walk_release: got state %0d x %0d required 0/120", o_state, o_x); end
  endtask

  task automatic test_clamp();
    send_key(K_L, 1'b0);
    ticks(58);
    checks++; if (o_x !== 10'd4 || o_facing !== 1'b1) begin errors++; $display("FAIL left_x4: got x %0d facing %0b required 4/1", o_x, o_facing); end
    wait_tick();
    checks++; if (o_x !== 10'd2) begin errors++; $display("FAIL left_x2: got %0d required 2", o_x); end
    wait_tick();
    checks++; if (o_x !== 10'd0) begin errors++; $display("FAIL left_x0: got %0d required 0", o_x); end
    wait_tick();
    checks++; if (o_x !== 10'd0 || o_state !== 3'd1) begin errors++; $display("FAIL left_clamp: got x %0d state %0d required 0/1", o_x, o_state); end
    send_key(K_L, 1'b1);
    send_key(K_R, 1'b0);
    ticks(304);
    checks++; if (o_x !== 10'd608) begin errors++; $display("FAIL right_x608: got %0d required 608", o_x); end
    ticks(2);
    checks++; if (o_x !== 10'd608 || o_facing !== 1'b0) begin errors++; $display("FAIL right_clamp: got x %0d facing %0b required 608/0", o_x, o_facing); end
    send_key(K_R, 1'b1);
    wait_tick();
    checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL right_release: got %0d required 0", o_state); end
  endtask

  task automatic test_jump();
    send_key(K_J, 1'b0);
    wait_tick();
    checks++; if (o_state !== 3'd2 || o_y !== 10'd400) begin errors++; $display("FAIL jump_enter: got state %0d y %0d required 2/400", o_state, o_y); end
    send_key(K_J, 1'b1);
    wait_tick();
    checks++; if (o_y !== 10'd388) begin errors++; $display("FAIL jump_y1: got %0d required 388", o_y); end
    wait_tick();
    checks++; if (o_y !== 10'd377) begin errors++; $display("FAIL jump_y2: got %0d required 377", o_y); end
    wait_tick();
    checks++; if (o_y !== 10'd367) begin errors++; $display("FAIL jump_y3: got %0d required 367", o_y); end
    send_key(K_A, 1'b0);
    wait_tick();
    checks++; if (o_state !== 3'd2 || o_y !== 10'd358) begin errors++; $display("FAIL jump_attack_ignored: got state %0d y %0d required 2/358", o_state, o_y); end
    send_key(K_A, 1'b1);
    ticks(8);
    checks++; if (o_y !== 10'd322) begin errors++; $display("FAIL jump_apex: got %0d required 322", o_y); end
`ifdef DOUBLE_JUMP_EN
    ticks(12);
`else
    send_key(K_J, 1'b0);
    ticks(2);
    checks++; if (o_y !== 10'd323) begin errors++; $display("FAIL jump_no_double: got %0d required 323", o_y); end
    send_key(K_J, 1'b1);
    ticks(10);
`endif
    checks++; if (o_y !== 10'd388 || o_state !== 3'd2) begin errors++; $display("FAIL jump_y24: got y %0d state %0d required 388/2", o_y, o_state); end
    wait_tick();
    checks++; if (o_y !== 10'd400 || o_state !== 3'd0) begin errors++; $display("FAIL jump_land: got y %0d state %0d required 400/0", o_y, o_state); end
  endtask

  task automatic test_attack();
    send_key(K_A, 1'b0);
    wait_tick();
    checks++; if (o_state !== 3'd3) begin errors++; $display("FAIL attack_enter: got %0d required 3", o_state); end
    ticks(5);
    send_key(K_J, 1'b0);
    ticks(6);
    checks++; if (o_state !== 3'd3 || o_x !== 10'd608 || o_y !== 10'd400) begin errors++; $display("FAIL attack_hold: got state %0d x %0d y %0d required 3/608/400", o_state, o_x, o_y); end
    wait_tick();
    checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL attack_end: got %0d required 0", o_state); end
    send_key(K_A, 1'b1);
    send_key(K_J, 1'b1);
    wait_tick();
    checks++; if (o_state !== 3'd0 || o_y !== 10'd400) begin errors++; $display("FAIL attack_idle: got state %0d y %0d required 0/400", o_state, o_y); end
  endtask

  task automatic test_hurt_death();
    send_hit(8'd30);
    checks++; if (o_hp !== 8'd70 || o_state !== 3'd4) begin errors++; $display("FAIL hurt_hit: got hp %0d state %0d required 70/4", o_hp, o_state); end
    ticks(5);
    send_hit(8'd50);
    checks++; if (o_hp !== 8'd70 || o_state !== 3'd4) begin errors++; $display("FAIL hurt_invuln: got hp %0d state %0d required 70/4", o_hp, o_state); end
    ticks(14);
    checks++; if (o_state !== 3'd4) begin errors++; $display("FAIL hurt_hold: got %0d required 4", o_state); end
    wait_tick();
    checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL hurt_end: got %0d required 0", o_state); end
    send_hit(8'd200);
    checks++; if (o_hp !== 8'd0 || o_state !== 3'd5) begin errors++; $display("FAIL death: got hp %0d state %0d required 0/5", o_hp, o_state); end
    send_key(K_L, 1'b0);
    ticks(3);
    checks++; if (o_state !== 3'd5 || o_x !== 10'd608 || o_facing !== 1'b0) begin errors++; $display("FAIL dead_frozen: got state %0d x %0d facing %0b required 5/608/0", o_state, o_x, o_facing); end
    send_key(K_L, 1'b1);
    test_reset("dead_reset");
  endtask

  task automatic test_hit_on_tick();
    int n = 0;
    send_key(K_R, 1'b0);
    wait_tick();
    checks++; if (o_x !== 10'd102 || o_state !== 3'd1) begin errors++; $display("FAIL hot_walk: got x %0d state %0d required 102/1", o_x, o_state); end
    @(negedge clk);
    while (!o_tick && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (!o_tick) begin
      checks++; errors++;
      $display("FAIL hot_tick_timeout: got o_tick %0b required 1", o_tick);
    end
    hit = 1'b1; hit_dmg = 8'd10;
    @(posedge clk); #1;
    hit = 1'b0;
    checks++; if (o_x !== 10'd102 || o_state !== 3'd4 || o_hp !== 8'd90) begin errors++; $display("FAIL hit_on_tick: got x %0d state %0d hp %0d required 102/4/90", o_x, o_state, o_hp); end
    send_key(K_R, 1'b1);
  endtask

`ifdef DOUBLE_JUMP_EN
  task automatic test_double_jump();
    test_reset("dj_reset");
    send_key(K_J, 1'b0);
    wait_tick();
    send_key(K_J, 1'b1);
    ticks(12);
    checks++; if (o_y !== 10'd322) begin errors++; $display("FAIL dj_apex: got %0d required 322", o_y); end
    send_key(K_J, 1'b0);
    ticks(2);
    checks++; if (o_y !== 10'd310) begin errors++; $display("FAIL dj_second: got %0d required 310", o_y); end
    send_key(K_J, 1'b1);
    wait_tick();
    send_key(K_J, 1'b0);
    ticks(2);
    checks++; if (o_y !== 10'd280) begin errors++; $display("FAIL dj_third_ignored: got %0d required 280", o_y); end
    send_key(K_J, 1'b1);
  endtask
`endif

  initial begin
    test_reset("reset");
    test_walk();
    test_clamp();
    test_jump();
    test_attack();
    test_hurt_death();
    test_hit_on_tick();
`ifdef DOUBLE_JUMP_EN
    test_double_jump();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
